// File: rtl/mac_accum_unit.sv
// mac_accum_unit: pipelined signed fixed-point MAC computing one bias-seeded dot product per vector
// Ports: clk/rst_n clock and async active-low reset; in_valid/in_ready/in_last beat handshake
//        with weight, data_in and bias (bias taken on a vector's first beat); out_valid/out_ready
//        result handshake with out_data (rounded, saturated), out_sat, out_ovf (sticky wrap) and
//        out_count (beats per vector, saturating).
module mac_accum_unit #(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 12,
   parameter int ACC_W  = 40,
   parameter int OUT_W  = 16,
   parameter int CNT_W  = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [DATA_W-1:0] weight,
   input  logic [DATA_W-1:0] data_in,
   input  logic [DATA_W-1:0] bias,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_sat,
   output logic              out_ovf,
   output logic [CNT_W-1:0]  out_count
);
   localparam int P_W = 2 * DATA_W;
   localparam logic signed [ACC_W:0] O_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] O_MIN = ~O_MAX;
   localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (FRAC_W-1);
   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;
   state_t state, nxt;
   logic [1:0] dcnt;
   logic accept, first, load;
   logic a_v, a_first, m_v, m_first, ovf, add_ovf, res_sat;
   logic signed [DATA_W-1:0] a_w, a_d, a_bias;
   logic signed [P_W-1:0] m_p;
   logic signed [ACC_W-1:0] acc, base, sum, p_ext;
   logic signed [ACC_W:0] rnd, r;
   logic [CNT_W-1:0] cnt;
   logic [OUT_W-1:0] res;
   assign accept = in_valid && in_ready;
   assign first = state == IDLE;
   // DRAIN waits for the last product to clear the pipeline; the load edge is the 4th after in_last
   assign load = state == DRAIN && dcnt == 2'd3;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (accept) nxt = in_last ? DRAIN : ACCUM;
         ACCUM:   if (accept && in_last) nxt = DRAIN;
         DRAIN:   if (dcnt == 2'd3) nxt = HOLD;
         HOLD:    if (out_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end
   // the first product of a vector adds onto the shifted bias instead of the stale accumulator
   assign p_ext = ACC_W'(m_p);
   assign base = m_first ? (ACC_W'(a_bias) <<< FRAC_W) : acc;
   assign sum = base + p_ext;
   assign add_ovf = (base[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
   // one extra bit so the rounding offset cannot wrap before the shift
   assign rnd = (ACC_W+1)'(acc) + HALF;
   assign r = rnd >>> FRAC_W;
   assign res_sat = r > O_MAX || r < O_MIN;
   assign res = r > O_MAX ? O_MAX[OUT_W-1:0] : r < O_MIN ? O_MIN[OUT_W-1:0] : r[OUT_W-1:0];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         in_ready <= 1'b0;
         out_valid <= 1'b0;
         dcnt <= 2'd0;
         a_v <= 1'b0;
         a_first <= 1'b0;
         a_w <= '0;
         a_d <= '0;
         a_bias <= '0;
         m_v <= 1'b0;
         m_first <= 1'b0;
         m_p <= '0;
         acc <= '0;
         ovf <= 1'b0;
         cnt <= '0;
         out_data <= '0;
         out_sat <= 1'b0;
         out_ovf <= 1'b0;
         out_count <= '0;
      end else begin
         state <= nxt;
         in_ready <= nxt == IDLE || nxt == ACCUM;
         out_valid <= nxt == HOLD;
         dcnt <= state == DRAIN ? dcnt + 2'd1 : 2'd0;
         a_v <= accept;
         m_v <= a_v;
         m_first <= a_first;
         if (accept) begin
            a_w <= weight;
            a_d <= data_in;
            a_first <= first;
            cnt <= first ? CNT_W'(1) : &cnt ? cnt : cnt + CNT_W'(1);
         end
         if (accept && first) a_bias <= bias;
         if (a_v) m_p <= P_W'(a_w) * P_W'(a_d);
         if (m_v) begin
            acc <= sum;
            ovf <= add_ovf || (!m_first && ovf);
         end
         if (load) begin
            out_data <= res;
            out_sat <= res_sat;
            out_ovf <= ovf;
            out_count <= cnt;
         end
      end
   end
endmodule

// File: tb/tb_mac_accum_unit.sv
// tb_mac_accum_unit: self-checking bench for mac_accum_unit
module tb_mac_accum_unit;
   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
   logic [15:0] weight = '0, data_in = '0, bias = '0;
   logic in_ready, out_valid, out_sat, out_ovf;
   logic [15:0] out_data;
   logic [9:0] out_count;
   int n_chk = 0, n_fail = 0;
   logic signed [15:0] vw [0:1099];
   logic signed [15:0] vd [0:1099];
   int gap [0:1099];
   typedef struct {
      int n;
      logic signed [15:0] b, w, d;
      int g2;
      logic [15:0] ed;
      logic es, eo;
      int ec;
   } vec_t;
   vec_t tbl [0:8];

   mac_accum_unit dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .weight(weight), .data_in(data_in), .bias(bias), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat), .out_ovf(out_ovf),
      .out_count(out_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_reset(input string nm);
      check({nm, " in_ready"}, in_ready, 0);
      check({nm, " out_valid"}, out_valid, 0);
      check({nm, " out_data"}, out_data, 0);
      check({nm, " out_sat"}, out_sat, 0);
      check({nm, " out_ovf"}, out_ovf, 0);
      check({nm, " out_count"}, out_count, 0);
   endtask

   // reference: exact integer dot product, wrapped into a 40-bit signed range, floor-rounded
   task automatic model(input int n, input logic signed [15:0] b, output logic [15:0] od,
                        output logic os, output logic oo, output int oc);
      longint lim, acc, q, r;
      lim = longint'(1) <<< 39;
      acc = longint'(b) * 4096;
      oo = 1'b0;
      for (int i = 0; i < n; i++) begin
         acc = acc + longint'(vw[i]) * longint'(vd[i]);
         if (acc >= lim) begin acc = acc - 2 * lim; oo = 1'b1; end
         else if (acc < -lim) begin acc = acc + 2 * lim; oo = 1'b1; end
      end
      q = acc + 2048;
      r = q / 4096;
      if (q < 0 && q % 4096 != 0) r = r - 1;
      os = r > 32767 || r < -32768;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      od = r[15:0];
      oc = n > 1023 ? 1023 : n;
   endtask

   // called and returns at a falling edge; the beat is accepted on the rising edge in between
   task automatic send_beat(input logic [15:0] w, input logic [15:0] d, input logic [15:0] b,
                            input logic last, input int g);
      int tmo;
      in_valid = 1'b0;
      repeat (g) @(negedge clk);
      in_valid = 1'b1; weight = w; data_in = d; bias = b; in_last = last;
      tmo = 0;
      while (!in_ready && tmo < 50) begin @(negedge clk); tmo++; end
      check("beat accepted", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic run_vec(input string nm, input int n, input logic [15:0] b, input logic [15:0] ed,
                          input logic es, input logic eo, input int ec, input int stall);
      int lat;
      out_ready = stall == 0;
      for (int i = 0; i < n; i++)
         send_beat(vw[i], vd[i], i == 0 ? b : 16'($urandom), i == n - 1, gap[i]);
      lat = 0;
      while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
      check({nm, " latency"}, lat, 4);
      check({nm, " out_data"}, out_data, ed);
      check({nm, " out_sat"}, out_sat, es);
      check({nm, " out_ovf"}, out_ovf, eo);
      check({nm, " out_count"}, out_count, ec);
      for (int s = 0; s < stall; s++) begin
         in_valid = 1'b1; in_last = 1'b1;
         weight = 16'($urandom); data_in = 16'($urandom); bias = 16'($urandom);
         @(negedge clk);
         check({nm, " stall in_ready"}, in_ready, 0);
         check({nm, " stall out_valid"}, out_valid, 1);
         check({nm, " stall out_data"}, out_data, ed);
      end
      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check({nm, " post out_valid"}, out_valid, 0);
      check({nm, " post in_ready"}, in_ready, 1);
      check({nm, " post out_data"}, out_data, ed);
   endtask

   initial begin
      logic [15:0] ed;
      logic es, eo;
      int n, ec, quiet;
      tbl[0] = '{1, 16'h0000, 16'h1000, 16'h2000, 0, 16'h2000, 1'b0, 1'b0, 1};
      tbl[1] = '{4, 16'h0800, 16'h1000, 16'h1000, 2, 16'h4800, 1'b0, 1'b0, 4};
      tbl[2] = '{4, 16'h7FFF, 16'h7FFF, 16'h7FFF, 0, 16'h7FFF, 1'b1, 1'b0, 4};
      tbl[3] = '{4, 16'h7FFF, 16'h7FFF, 16'h8000, 0, 16'h8000, 1'b1, 1'b0, 4};
      tbl[4] = '{1, 16'h0000, 16'h0001, 16'h0800, 0, 16'h0001, 1'b0, 1'b0, 1};
      tbl[5] = '{1, 16'h0000, 16'hFFFF, 16'h0800, 0, 16'h0000, 1'b0, 1'b0, 1};
      tbl[6] = '{1, 16'h0000, 16'hFFFF, 16'h0801, 0, 16'hFFFF, 1'b0, 1'b0, 1};
      tbl[7] = '{1, 16'h1000, 16'h0000, 16'h0000, 0, 16'h1000, 1'b0, 1'b0, 1};
      tbl[8] = '{2, 16'h0800, 16'h1000, 16'hE000, 0, 16'hC800, 1'b0, 1'b0, 2};
      #12;
      check_reset("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      foreach (tbl[k]) begin
         for (int i = 0; i < tbl[k].n; i++) begin
            vw[i] = tbl[k].w; vd[i] = tbl[k].d; gap[i] = i == 2 ? tbl[k].g2 : 0;
         end
         run_vec($sformatf("tbl%0d", k), tbl[k].n, tbl[k].b, tbl[k].ed, tbl[k].es, tbl[k].eo,
                 tbl[k].ec, 0);
      end
      for (int k = 0; k < 25; k++) begin
         logic [15:0] b;
         n = $urandom_range(1, 8);
         b = 16'($urandom);
         for (int i = 0; i < n; i++) begin
            vw[i] = 16'($urandom); vd[i] = 16'($urandom); gap[i] = $urandom_range(0, 2);
         end
         model(n, b, ed, es, eo, ec);
         run_vec($sformatf("rnd%0d", k), n, b, ed, es, eo, ec, $urandom_range(0, 3));
      end
      vw[0] = 16'h1000; vd[0] = 16'h3000; gap[0] = 0;
      run_vec("stall", 1, 16'h0000, 16'h3000, 1'b0, 1'b0, 1, 10);
      vw[0] = 16'h2000; vd[0] = 16'h0800;
      run_vec("after stall", 1, 16'h0000, 16'h1000, 1'b0, 1'b0, 1, 0);
      send_beat(16'h1000, 16'h1000, 16'h0400, 1'b0, 0);
      send_beat(16'h1000, 16'h1000, 16'h0400, 1'b0, 0);
      rst_n = 1'b0;
      #1;
      check_reset("midvec reset");
      @(negedge clk);
      rst_n = 1'b1;
      quiet = 0;
      for (int i = 0; i < 12; i++) begin @(negedge clk); quiet += out_valid; end
      check("no output after reset", quiet, 0);
      vw[0] = 16'h1000; vd[0] = 16'h1000; gap[0] = 0;
      run_vec("fresh", 1, 16'h0000, 16'h1000, 1'b0, 1'b0, 1, 0);
      for (int i = 0; i < 1030; i++) begin vw[i] = 16'h8000; vd[i] = 16'h8000; gap[i] = 0; end
      model(1030, 16'h0000, ed, es, eo, ec);
      run_vec("long", 1030, 16'h0000, ed, es, eo, ec, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
